// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the constant quotient bit pattern for division by zero.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Every quotient bit is set when the divisor is zero.
  localparam logic DBZ_QUOT_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic is_valid_op(input logic [2:0] op);
    return op <= MD_MTLO;
  endfunction

  function automatic logic is_iter_op(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage issue bundle and HI/LO/status return for the mul/div unit.
// The issuer drives the master side; the unit sits on the slave side.
interface mul_div_unit_if #(parameter int WIDTH = 32);

  logic             start_e;
  logic             flush_e;
  logic [2:0]       op_e;
  logic [WIDTH-1:0] a_e;
  logic [WIDTH-1:0] b_e;
  logic             mf_op_d;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall_md;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start_e, flush_e, op_e, a_e, b_e, mf_op_d,
    input  hi, lo, busy, stall_md, done, div_by_zero
  );

  modport slave (
    input  start_e, flush_e, op_e, a_e, b_e, mf_op_d,
    output hi, lo, busy, stall_md, done, div_by_zero
  );

endinterface

// File: rtl/md_iter_core.sv
// Radix-2 datapath: one WIDTH+1-bit adder/subtractor feeding a 2*WIDTH-bit
// shift register, used as shift-add multiplier or restoring divider.
module md_iter_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0]   op_a;
  logic [WIDTH:0]   op_b;
  logic [WIDTH:0]   sum;
  logic             carry;

  // Divide subtracts via two's complement; carry-out set means no borrow.
  always_comb begin
    op_a = div_i ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
    op_b = div_i ? ~{1'b0, b_q} : {1'b0, b_q};
    {carry, sum} = {1'b0, op_a} + {1'b0, op_b} + {{(WIDTH+1){1'b0}}, div_i};
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    b_d  = b_q;
    if (load_i) begin
      hi_d = '0;
      lo_d = a_i;
      b_d  = b_i;
    end else if (step_i) begin
      if (div_i) begin
        hi_d = carry ? sum[WIDTH-1:0] : op_a[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], carry};
      end else if (lo_q[0]) begin
        {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
      end else begin
        {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO. Owns the issue
// handshake, the IDLE/RUN/FIX sequencer, sign handling and the stall request.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  mul_div_unit_if.slave  md
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH < 4) begin : g_width_check
    $error("mul_div_unit: WIDTH must be at least 4");
  end

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             b_zero_q, b_zero_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             accept;
  logic             accept_iter;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    accept      = (state_q == IDLE) && md.start_e && !md.flush_e && is_valid_op(md.op_e);
    accept_iter = accept && is_iter_op(md.op_e);
    a_neg       = is_signed_op(md.op_e) && md.a_e[WIDTH-1];
    b_neg       = is_signed_op(md.op_e) && md.b_e[WIDTH-1];
    a_mag       = a_neg ? -md.a_e : md.a_e;
    b_mag       = b_neg ? -md.b_e : md.b_e;
    prod        = {core_hi, core_lo};
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .load_i (accept_iter),
    .step_i (state_q == RUN),
    .div_i  (div_q),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_raw_d   = a_raw_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    dbz_d     = dbz_q;
    done_d    = (state_q == FIX);

    case (state_q)
      IDLE: begin
        if (accept) begin
          dbz_d = 1'b0;
          if (md.op_e == MD_MTHI) begin
            hi_d = md.a_e;
          end else if (md.op_e == MD_MTLO) begin
            lo_d = md.a_e;
          end else begin
            state_d   = RUN;
            cnt_d     = '0;
            div_d     = md.op_e[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            b_zero_d  = (md.b_e == '0);
            a_raw_d   = md.a_e;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!div_q) begin
          {hi_d, lo_d} = neg_res_q ? -prod : prod;
        end else if (b_zero_q) begin
          // Quotient pattern is fixed; remainder is the dividend exactly as issued.
          lo_d  = {WIDTH{DBZ_QUOT_BIT}};
          hi_d  = a_raw_q;
          dbz_d = 1'b1;
        end else begin
          lo_d = neg_res_q ? -core_lo : core_lo;
          hi_d = neg_rem_q ? -core_hi : core_hi;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_raw_q   <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_raw_q   <= a_raw_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign md.hi          = hi_q;
  assign md.lo          = lo_q;
  assign md.busy        = (state_q != IDLE);
  assign md.stall_md    = (state_q != IDLE) && (md.mf_op_d || md.start_e);
  assign md.done        = done_q;
  assign md.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: hand-computed HI/LO results,
// latency, stall, flush, div-by-zero and asynchronous reset behaviour.
module tb_mul_div_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mul_div_unit_if #(.WIDTH(W)) md_bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .md    (md_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    md_bus.start_e = 1'b1;
    md_bus.op_e    = op;
    md_bus.a_e     = a;
    md_bus.b_e     = b;
    @(negedge clk);
    md_bus.start_e = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (md_bus.busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 200) check("busy_timeout", 64'(cycles), 64'd0);
  endtask

  task automatic run_iter(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
    int cyc;
    issue(op, a, b);
    wait_idle(cyc);
    check({tag, "_cycles"}, 64'(cyc), 64'd33);
    check({tag, "_done"}, 64'(md_bus.done), 64'd1);
    check({tag, "_hi"}, 64'(md_bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(md_bus.lo), 64'(exp_lo));
    $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h cycles=%0d",
             op, a, b, md_bus.hi, md_bus.lo, cyc);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(md_bus.done), 64'd0);
  endtask

  initial begin
    int cyc;
    int stall_cnt;
    int done_cnt;

    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    md_bus.start_e = 1'b0;
    md_bus.flush_e = 1'b0;
    md_bus.op_e    = 3'd0;
    md_bus.a_e     = '0;
    md_bus.b_e     = '0;
    md_bus.mf_op_d = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hi", 64'(md_bus.hi), 64'd0);
    check("rst_lo", 64'(md_bus.lo), 64'd0);
    check("rst_busy", 64'(md_bus.busy), 64'd0);
    check("rst_done", 64'(md_bus.done), 64'd0);
    check("rst_dbz", 64'(md_bus.div_by_zero), 64'd0);

    run_iter("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_iter("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_iter("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_iter("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_iter("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    check("div_negb_dbz", 64'(md_bus.div_by_zero), 64'd0);

    run_iter("divu_zero", 3'd3, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF);
    check("divu_zero_dbz", 64'(md_bus.div_by_zero), 64'd1);

    issue(3'd5, 32'h0000_1234, 32'd0);
    $display("op=5 a=0x00001234 -> lo=0x%08h dbz=%0d", md_bus.lo, md_bus.div_by_zero);
    check("mtlo_lo", 64'(md_bus.lo), 64'h1234);
    check("mtlo_dbz", 64'(md_bus.div_by_zero), 64'd0);
    check("mtlo_busy", 64'(md_bus.busy), 64'd0);
    check("mtlo_done", 64'(md_bus.done), 64'd0);

    issue(3'd4, 32'h0000_CAFE, 32'd0);
    $display("op=4 a=0x0000cafe -> hi=0x%08h", md_bus.hi);
    check("mthi_hi", 64'(md_bus.hi), 64'hCAFE);
    check("mthi_lo_kept", 64'(md_bus.lo), 64'h1234);

    run_iter("div_zero_sgn", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    check("div_zero_sgn_dbz", 64'(md_bus.div_by_zero), 64'd1);

    // Flushed and invalid issues must leave everything untouched.
    md_bus.flush_e = 1'b1;
    issue(3'd4, 32'h0000_DEAD, 32'd0);
    $display("flushed op=4 -> hi=0x%08h busy=%0d", md_bus.hi, md_bus.busy);
    check("flush_mthi_hi", 64'(md_bus.hi), 64'hFFFF_FFF9);
    issue(3'd0, 32'd3, 32'd3);
    $display("flushed op=0 -> busy=%0d", md_bus.busy);
    check("flush_mult_busy", 64'(md_bus.busy), 64'd0);
    md_bus.flush_e = 1'b0;
    issue(3'd6, 32'h0000_BEEF, 32'd1);
    $display("op=6 -> hi=0x%08h lo=0x%08h busy=%0d", md_bus.hi, md_bus.lo, md_bus.busy);
    check("noop_busy", 64'(md_bus.busy), 64'd0);
    check("noop_lo", 64'(md_bus.lo), 64'hFFFF_FFFF);
    check("noop_dbz", 64'(md_bus.div_by_zero), 64'd1);

    // DIVU with a waiting MF read and a held second issue, then back-to-back accept.
    @(negedge clk);
    md_bus.start_e = 1'b1;
    md_bus.op_e    = 3'd3;
    md_bus.a_e     = 32'd100;
    md_bus.b_e     = 32'd7;
    @(negedge clk);
    md_bus.mf_op_d = 1'b1;
    md_bus.op_e    = 3'd0;
    md_bus.a_e     = 32'd3;
    md_bus.b_e     = 32'd5;
    stall_cnt = 0;
    cyc = 0;
    while (md_bus.busy && cyc < 200) begin
      if (md_bus.stall_md) stall_cnt++;
      cyc++;
      @(negedge clk);
    end
    $display("divu 100/7 with stall -> hi=0x%08h lo=0x%08h stalls=%0d", md_bus.hi, md_bus.lo, stall_cnt);
    check("stall_cycles", 64'(stall_cnt), 64'd33);
    check("stall_busy_cycles", 64'(cyc), 64'd33);
    check("stall_divu_lo", 64'(md_bus.lo), 64'd14);
    check("stall_divu_hi", 64'(md_bus.hi), 64'd2);
    check("stall_done", 64'(md_bus.done), 64'd1);
    check("stall_released", 64'(md_bus.stall_md), 64'd0);
    @(negedge clk);
    md_bus.start_e = 1'b0;
    md_bus.mf_op_d = 1'b0;
    check("b2b_busy", 64'(md_bus.busy), 64'd1);
    wait_idle(cyc);
    $display("b2b mult 3*5 -> hi=0x%08h lo=0x%08h", md_bus.hi, md_bus.lo);
    check("b2b_lo", 64'(md_bus.lo), 64'd15);
    check("b2b_hi", 64'(md_bus.hi), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    issue(3'd1, 32'h0000_0010, 32'h0000_0010);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    $display("reset mid-mult -> hi=0x%08h lo=0x%08h busy=%0d", md_bus.hi, md_bus.lo, md_bus.busy);
    check("arst_busy", 64'(md_bus.busy), 64'd0);
    check("arst_hi", 64'(md_bus.hi), 64'd0);
    check("arst_lo", 64'(md_bus.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_bus.done) done_cnt++;
    end
    check("arst_no_done", 64'(done_cnt), 64'd0);
    check("arst_lo_held", 64'(md_bus.lo), 64'd0);
    run_iter("mult_after_rst", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers. It replaces the current single-cycle divide-only path (HasDiv/DivHi/DivLo).
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO issued from the execute stage. Runs multi-cycle radix-2 operations.
- Gives the hazard unit a stall request so MFHI/MFLO and new issues wait for completion.

Parameters:
- WIDTH, 32: operand, HI and LO width; must be >= 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start_e  in  1  op issue valid in execute
- flush_e  in  1  kills the issue presented in the same cycle
- op_e  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, others=no-op
- a_e  in  WIDTH  rs operand (dividend / multiplicand / MT source)
- b_e  in  WIDTH  rt operand (divisor / multiplier)
- mf_op_d  in  1  MFHI/MFLO currently in decode
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- stall_md  out  1  to hazard unit: busy & (mf_op_d | start_e)
- done  out  1  one-cycle pulse after HI/LO update
- div_by_zero  out  1  sticky per op; set at DIV/DIVU completion when b=0, cleared on next accepted issue

Behaviour:
- Reset (async, any time including mid-operation): state IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0. Results of an in-flight op are discarded, and no done pulse follows.
- Issue is accepted only when state==IDLE, start_e=1, flush_e=0 and op_e is 0..5.
- When busy, start_e is ignored and stall_md=1; the issuer holds its inputs.
- MTHI/MTLO: at the accepting edge, hi (or lo) <= a_e. Single cycle. busy stays 0 and there is no done pulse.
- MULT/DIV families: IDLE -> RUN on acceptance, latching magnitudes and sign flags.
  - Unsigned ops use the raw operands, with sign flags 0.
  - RUN lasts exactly WIDTH cycles, with one shift-add (mul) or restoring shift-subtract (div) per cycle.
  - RUN -> FIX for 1 cycle: sign correction, then hi/lo written at the end of FIX.
  - FIX -> IDLE. done=1 in the first IDLE cycle.
- busy=1 in RUN and FIX. Total: WIDTH+1 busy cycles. HI/LO are valid from the cycle done is high.
- Multiply: 2*WIDTH-bit product; hi=upper, lo=lower. Signed product is negated in FIX when sign(a)^sign(b).
- Divide: lo=quotient, hi=remainder.
  - Signed: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend (truncating division).
  - Most-negative / -1: lo=most-negative, hi=0 (falls out of magnitude arithmetic; no trap).
  - Divisor 0, both DIV and DIVU: lo=all ones, hi=a_e as issued, div_by_zero=1. Still takes the full WIDTH+1 cycles.
- The same edge may accept an issue while done is high (back-to-back issue allowed).
- flush_e with start_e: no state change, no register write.
- hi/lo hold their values during RUN. An MF read while busy is blocked via stall_md, never served stale.

Decomposition:
- Package md_pkg holds:
  - op encodings (MD_MULT..MD_MTLO)
  - state enum IDLE/RUN/FIX
  - localparam for the div-by-zero quotient pattern
- One sub-module, md_iter_core: shared WIDTH+1-bit adder/subtractor plus the 2*WIDTH shift register, selected by mul/div mode.
- The top keeps the FSM, counter, sign flags, HI/LO and handshake.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFD (-3), b=7 -> busy for 33 cycles, then done; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1. A following MTLO a=0x1234 clears div_by_zero; lo=0x1234 on the next cycle.
- During DIVU, mf_op_d=1 and a second start_e -> stall_md=1 through cycle 33, second op ignored until IDLE. With flush_e=1 at issue -> hi/lo unchanged, busy stays 0.
- Assert reset at cycle 10 of a MULT -> busy=0, hi=lo=0 immediately, no done pulse. A new MULT 6*7 afterwards -> lo=42, hi=0.
